// File: rtl/fft_seq_pkg.sv
// Shared constants and the sample-format helper for the FFT frame sequencer.
// FFT_SEQ_DC_REMOVE_EN selects offset-binary to two's-complement conversion of ADC codes.
package fft_seq_pkg;

   localparam int unsigned ADC_W = 12;
   localparam int unsigned FFT_W = 16;
   localparam logic [ADC_W-1:0] DC_OFFSET = 12'd2048;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] PRIME  = 2'd1;
   localparam logic [1:0] STREAM = 2'd2;
   localparam logic [1:0] FLUSH  = 2'd3;

   function automatic logic [FFT_W-1:0] adc_to_fft(input logic [ADC_W-1:0] code);
`ifdef FFT_SEQ_DC_REMOVE_EN
      logic [ADC_W-1:0] centred;
      centred = code - DC_OFFSET;
      return {{(FFT_W-ADC_W){centred[ADC_W-1]}}, centred};
`else
      return {{(FFT_W-ADC_W){1'b0}}, code};
`endif
   endfunction

endpackage

// File: rtl/fft_seq_decimator.sv
// Keeps 1 of every ratio+1 valid ADC samples; the ratio is frozen for the length of a frame.
module fft_seq_decimator
   import fft_seq_pkg::*;
#(
   parameter int unsigned DECIM_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               reload_i,
   input  logic               active_i,
   input  logic               adc_valid_i,
   input  logic [DECIM_W-1:0] decim_i,
   output logic               accept_o
);

   logic [DECIM_W-1:0] dcnt_q;
   logic [DECIM_W-1:0] ratio_q;

   assign accept_o = active_i && adc_valid_i && (dcnt_q == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dcnt_q  <= '0;
         ratio_q <= '0;
      end else if (start_i) begin
         dcnt_q  <= '0;
         ratio_q <= decim_i;
      end else begin
         if (reload_i) begin
            ratio_q <= decim_i;
         end
         // >= rather than == so a ratio lowered at a frame boundary cannot strand the counter
         if (active_i && adc_valid_i) begin
            dcnt_q <= (dcnt_q >= ratio_q) ? '0 : dcnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frames decimated ADC samples into a streaming FFT: primes, streams with capture windows, and
// drains the last frame with zero-fill. FFT_SEQ_DC_REMOVE_EN selects DC-removed sample format.
module fft_frame_sequencer
   import fft_seq_pkg::*;
#(
   parameter int unsigned N_POINTS = 1024,
   parameter int unsigned LOG2N    = 10,
   parameter int unsigned DECIM_W  = 8
) (
   input  logic               CLK,
   input  logic               rst,
   input  logic               run,
   input  logic               single_shot,
   input  logic [DECIM_W-1:0] decim,
   input  logic               adc_valid,
   input  logic [ADC_W-1:0]   adc_data,
   input  logic               buf_ready,
   output logic               fft_enable,
   output logic [FFT_W-1:0]   fft_din_re,
   output logic               capture_en,
   output logic               capture_sof,
   output logic               capture_eof,
   output logic               busy,
   output logic [15:0]        frame_cnt,
   output logic               overrun
);

   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

   logic [1:0]       state_q, state_d;
   logic [LOG2N-1:0] in_idx_q;
   logic [LOG2N-1:0] out_idx_q;
   logic             single_q;
   logic             cap_ok_q;
   logic             en_q;
   logic             cap_q;
   logic [FFT_W-1:0] din_q;
   logic [15:0]      frame_cnt_q;
   logic             overrun_q;

   logic start_req, loading, cap_phase, accept, push, last_push, frame_first, cap_now;

   // The FSM tracks the push side; the registered outputs trail it by one cycle.
   assign start_req   = (state_q == IDLE) && (run || single_shot);
   assign loading     = (state_q == PRIME) || (state_q == STREAM);
   assign cap_phase   = (state_q == STREAM) || (state_q == FLUSH);
   assign push        = (state_q == FLUSH) || accept;
   assign last_push   = push && (in_idx_q == LAST_IDX);
   assign frame_first = push && cap_phase && (in_idx_q == '0);
   assign cap_now     = frame_first ? buf_ready : cap_ok_q;

   fft_seq_decimator #(
      .DECIM_W (DECIM_W)
   ) u_decimator (
      .clk_i       (CLK),
      .rst_i       (rst),
      .start_i     (start_req),
      .reload_i    (loading && last_push),
      .active_i    (loading),
      .adc_valid_i (adc_valid),
      .decim_i     (decim),
      .accept_o    (accept)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (run || single_shot) state_d = PRIME;
         PRIME:   if (last_push) state_d = (run && !single_q) ? STREAM : FLUSH;
         STREAM:  if (last_push && !run) state_d = FLUSH;
         FLUSH:   if (last_push) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q     <= IDLE;
         in_idx_q    <= '0;
         out_idx_q   <= '0;
         single_q    <= 1'b0;
         cap_ok_q    <= 1'b0;
         en_q        <= 1'b0;
         cap_q       <= 1'b0;
         din_q       <= '0;
         frame_cnt_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_req) begin
            in_idx_q <= '0;
            single_q <= !run;
         end else if (push) begin
            in_idx_q <= in_idx_q + 1'b1;
         end
         if (frame_first) begin
            cap_ok_q <= buf_ready;
            if (!buf_ready) begin
               overrun_q <= 1'b1;
            end
         end
         en_q      <= push;
         cap_q     <= push && cap_phase && cap_now;
         out_idx_q <= in_idx_q;
         din_q     <= (push && (state_q != FLUSH)) ? adc_to_fft(adc_data) : '0;
         if (capture_eof) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
      end
   end

   assign fft_enable  = en_q;
   assign fft_din_re  = din_q;
   assign capture_en  = en_q && cap_q;
   assign capture_sof = capture_en && (out_idx_q == '0);
   assign capture_eof = capture_en && (out_idx_q == LAST_IDX);
   assign busy        = (state_q != IDLE) || en_q;
   assign frame_cnt   = frame_cnt_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed self-checking bench for fft_frame_sequencer with 8-point frames.
module tb_fft_frame_sequencer;

   logic        CLK = 1'b0;
   logic        rst = 1'b0;
   logic        run = 1'b0;
   logic        single_shot = 1'b0;
   logic [7:0]  decim = 8'd0;
   logic        adc_valid = 1'b0;
   logic [11:0] adc_data = 12'd0;
   logic        buf_ready = 1'b1;
   logic        fft_enable;
   logic [15:0] fft_din_re;
   logic        capture_en;
   logic        capture_sof;
   logic        capture_eof;
   logic        busy;
   logic [15:0] frame_cnt;
   logic        overrun;

   int total = 0;
   int bad = 0;

`ifdef FFT_SEQ_DC_REMOVE_EN
   localparam logic [15:0] DBASE = 16'hF900;
   localparam logic [15:0] D000  = 16'hF800;
   localparam logic [15:0] DFFF  = 16'h07FF;
`else
   localparam logic [15:0] DBASE = 16'h0100;
   localparam logic [15:0] D000  = 16'h0000;
   localparam logic [15:0] DFFF  = 16'h0FFF;
`endif

   fft_frame_sequencer #(
      .N_POINTS (8),
      .LOG2N    (3),
      .DECIM_W  (8)
   ) dut (
      .CLK         (CLK),
      .rst         (rst),
      .run         (run),
      .single_shot (single_shot),
      .decim       (decim),
      .adc_valid   (adc_valid),
      .adc_data    (adc_data),
      .buf_ready   (buf_ready),
      .fft_enable  (fft_enable),
      .fft_din_re  (fft_din_re),
      .capture_en  (capture_en),
      .capture_sof (capture_sof),
      .capture_eof (capture_eof),
      .busy        (busy),
      .frame_cnt   (frame_cnt),
      .overrun     (overrun)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; run = 1'b0; single_shot = 1'b0; decim = 8'd0;
      adc_valid = 1'b0; adc_data = 12'd0; buf_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      total++;
      if ({fft_enable, capture_en, capture_sof, capture_eof, busy, overrun} !== 6'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b want 000000",
                  {fft_enable, capture_en, capture_sof, capture_eof, busy, overrun});
      end
      total++;
      if (fft_din_re !== 16'h0000) begin
         bad++; $display("FAIL reset_din: got %h want 0000", fft_din_re);
      end
      total++;
      if (frame_cnt !== 16'd0) begin
         bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
      end
   endtask

   task automatic test_single_shot();
      logic [3:0]  exp_flags;
      logic [15:0] exp_din;
      apply_reset();
      adc_valid = 1'b1; single_shot = 1'b1; adc_data = 12'h100;
      tick();
      single_shot = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++; $display("FAIL single_busy_start: got %b want 1", busy);
      end
      for (int t = 1; t <= 18; t++) begin
         adc_data = 12'h100 + 12'(t);
         tick();
         exp_flags = {t <= 16, (t >= 9 && t <= 16), t == 9, t == 16};
         total++;
         if ({fft_enable, capture_en, capture_sof, capture_eof} !== exp_flags) begin
            bad++;
            $display("FAIL single_flags t=%0d: got %b want %b", t,
                     {fft_enable, capture_en, capture_sof, capture_eof}, exp_flags);
         end
         if (t <= 16) begin
            exp_din = (t <= 8) ? DBASE + 16'(t) : 16'h0000;
            total++;
            if (fft_din_re !== exp_din) begin
               bad++; $display("FAIL single_din t=%0d: got %h want %h", t, fft_din_re, exp_din);
            end
         end
         if (t == 17) begin
            total++;
            if ({busy, frame_cnt} !== {1'b0, 16'd1}) begin
               bad++;
               $display("FAIL single_end: got busy=%b frame_cnt=%0d want busy=0 frame_cnt=1",
                        busy, frame_cnt);
            end
         end
      end
   endtask

   task automatic test_continuous();
      int n_en = 0;
      int n_sof = 0;
      int n_eof = 0;
      apply_reset();
      adc_valid = 1'b1; run = 1'b1;
      tick();
      for (int t = 1; t <= 34; t++) begin
         if (t == 20) run = 1'b0;
         adc_data = 12'(t * 7);
         tick();
         n_en += int'(fft_enable);
         n_sof += int'(capture_sof);
         n_eof += int'(capture_eof);
         total++;
         if (capture_en !== (t >= 9 && t <= 32)) begin
            bad++; $display("FAIL cont_capture t=%0d: got %b want %b", t, capture_en,
                            (t >= 9 && t <= 32));
         end
      end
      total++;
      if (n_en != 32 || n_sof != 3 || n_eof != 3) begin
         bad++; $display("FAIL cont_counts: got en=%0d sof=%0d eof=%0d want 32 3 3",
                         n_en, n_sof, n_eof);
      end
      total++;
      if ({frame_cnt, overrun, busy} !== {16'd3, 1'b0, 1'b0}) begin
         bad++; $display("FAIL cont_end: got frame_cnt=%0d overrun=%b busy=%b want 3 0 0",
                         frame_cnt, overrun, busy);
      end
   endtask

   task automatic test_decimation();
      logic exp_en;
      int   waited = 0;
      apply_reset();
      adc_valid = 1'b1; run = 1'b1; decim = 8'd2;
      tick();
      for (int t = 1; t <= 27; t++) begin
         if (t == 5) decim = 8'd0;
         tick();
         exp_en = (t <= 22) ? ((t - 1) % 3 == 0) : (t >= 24);
         total++;
         if (fft_enable !== exp_en) begin
            bad++; $display("FAIL decim_enable t=%0d: got %b want %b", t, fft_enable, exp_en);
         end
      end
      run = 1'b0;
      while (busy === 1'b1 && waited < 60) begin
         tick();
         waited++;
      end
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL decim_drain: got busy=%b want 0 within 60 cycles", busy);
      end
   endtask

   task automatic test_overrun();
      logic exp_cen;
      apply_reset();
      adc_valid = 1'b1; run = 1'b1;
      tick();
      for (int t = 1; t <= 42; t++) begin
         buf_ready = (t != 17);
         run = (t < 28);
         tick();
         exp_cen = (t >= 9 && t <= 16) || (t >= 25 && t <= 40);
         total++;
         if ({fft_enable, capture_en} !== {t <= 40, exp_cen}) begin
            bad++; $display("FAIL ovr_flags t=%0d: got %b want %b", t,
                            {fft_enable, capture_en}, {t <= 40, exp_cen});
         end
         if (t == 16 || t == 17) begin
            total++;
            if (overrun !== (t == 17)) begin
               bad++; $display("FAIL ovr_sticky t=%0d: got %b want %b", t, overrun, t == 17);
            end
         end
         if (t == 24) begin
            total++;
            if (frame_cnt !== 16'd1) begin
               bad++; $display("FAIL ovr_skip_cnt: got %0d want 1", frame_cnt);
            end
         end
      end
      total++;
      if ({frame_cnt, overrun} !== {16'd3, 1'b1}) begin
         bad++; $display("FAIL ovr_end: got frame_cnt=%0d overrun=%b want 3 1", frame_cnt, overrun);
      end
   endtask

   task automatic test_reset_mid_frame();
      apply_reset();
      adc_valid = 1'b1; run = 1'b1;
      tick();
      for (int t = 1; t <= 22; t++) tick();
      total++;
      if ({capture_en, frame_cnt} !== {1'b1, 16'd1}) begin
         bad++; $display("FAIL midrst_pre: got cap=%b frame_cnt=%0d want 1 1",
                         capture_en, frame_cnt);
      end
      rst = 1'b1;
      tick();
      total++;
      if ({fft_enable, capture_en, capture_sof, capture_eof, busy, overrun, frame_cnt, fft_din_re}
          !== 38'd0) begin
         bad++; $display("FAIL midrst_clear: en=%b cap=%b busy=%b cnt=%0d din=%h want all 0",
                         fft_enable, capture_en, busy, frame_cnt, fft_din_re);
      end
      rst = 1'b0; run = 1'b0;
      for (int t = 0; t < 12; t++) begin
         tick();
         total++;
         if ({fft_enable, busy} !== 2'b00) begin
            bad++; $display("FAIL midrst_no_flush t=%0d: got en=%b busy=%b want 0 0",
                            t, fft_enable, busy);
         end
      end
   endtask

   task automatic test_dc_format();
      int waited = 0;
      apply_reset();
      adc_valid = 1'b1; single_shot = 1'b1; adc_data = 12'h555;
      tick();
      single_shot = 1'b0;
      adc_data = 12'h000;
      tick();
      total++;
      if ({fft_enable, fft_din_re} !== {1'b1, D000}) begin
         bad++; $display("FAIL dc_low: got en=%b din=%h want 1 %h", fft_enable, fft_din_re, D000);
      end
      adc_data = 12'hFFF;
      tick();
      total++;
      if ({fft_enable, fft_din_re} !== {1'b1, DFFF}) begin
         bad++; $display("FAIL dc_high: got en=%b din=%h want 1 %h", fft_enable, fft_din_re, DFFF);
      end
      while (busy === 1'b1 && waited < 40) begin
         tick();
         waited++;
      end
      total++;
      if ({busy, frame_cnt} !== {1'b0, 16'd1}) begin
         bad++; $display("FAIL dc_end: got busy=%b frame_cnt=%0d want 0 1", busy, frame_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single_shot();
      test_continuous();
      test_decimation();
      test_overrun();
      test_reset_mid_frame();
      test_dc_format();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Sits between the XADC AXI-stream output, FFT_top and Output_buffer.
- Decimates ADC samples and gates `FFT_top.enable` in N-point frames.
- The FFT is streaming: frame k's spectrum emerges while frame k+1 is loaded. The block therefore primes the first frame, marks capture windows for the output buffer, and drains the last frame with zero-fill.
- Replaces the direct `m_axis_tvalid` → `enable` wiring.

Parameters:
- N_POINTS, 1024, FFT frame length in samples; power of two.
- LOG2N, 10, log2(N_POINTS).
- DECIM_W, 8, width of the decimation ratio.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = continuous acquisition, 0 = stop after the current frame.
- single_shot  in  1  one-cycle pulse in IDLE; acquire exactly one frame.
- decim  in  DECIM_W  keep 1 of every decim+1 valid samples; 0 = keep all.
- adc_valid  in  1  ADC sample strobe (m_axis_tvalid).
- adc_data  in  12  ADC code (m_axis_tdata[11:0]).
- buf_ready  in  1  output buffer can absorb one full frame.
- fft_enable  out  1  one-cycle push into FFT_top.
- fft_din_re  out  16  sample to FFT_top.xb_re; valid with fft_enable.
- capture_en  out  1  output buffer should latch the FFT output on this cycle.
- capture_sof  out  1  first bin of a captured frame (with capture_en).
- capture_eof  out  1  last bin of a captured frame (with capture_en).
- busy  out  1  state != IDLE.
- frame_cnt  out  16  frames captured since reset; wraps.
- overrun  out  1  sticky; set when a frame capture was skipped.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-frame aborts immediately; the FFT pipeline contents are discarded and not flushed.
- Decimation counter dcnt:
  - Sample accepted when adc_valid && dcnt==0.
  - On each adc_valid, dcnt <= (dcnt==decim) ? 0 : dcnt+1.
  - decim is sampled at frame start; changes mid-frame are ignored.
- Accepted sample → fft_enable=1 and fft_din_re registered on the next cycle (latency 1).
- Sample index idx (LOG2N bits) counts fft_enable pulses and wraps at N_POINTS-1.
- States:
  - IDLE: outputs idle. run=1 or single_shot=1 → PRIME, with idx=0 and dcnt=0.
  - PRIME: load the first frame, capture_en=0. When idx wraps: if run=1 and not single-shot → STREAM; else → FLUSH.
  - STREAM: load frame k+1 while outputs of frame k emerge. capture_en = fft_enable && cap_ok.
    - cap_ok is latched at idx==0 from buf_ready.
    - If buf_ready=0 at idx==0: frame still loads, capture suppressed, overrun<=1.
    - At wrap: if run=0 → FLUSH, else stay.
  - FLUSH: fft_enable=1 every cycle, fft_din_re=0, ADC samples ignored. capture_en per cap_ok, latched at FLUSH entry. After N_POINTS pushes → IDLE.
- capture_sof = capture_en && idx==0; capture_eof = capture_en && idx==N_POINTS-1.
- frame_cnt increments on capture_eof.
- Simultaneous events:
  - run and single_shot both high in IDLE: run wins (continuous).
  - single_shot outside IDLE: ignored.
  - adc_valid during FLUSH: dropped, no overrun.
- busy = 1 from the cycle after the start request until the cycle after the last FLUSH push.

Optional Feature:
- Macro: FFT_SEQ_DC_REMOVE_EN.
- Defined: fft_din_re = sign-extended (adc_data − 12'd2048), a signed 16-bit value in the range −2048..2047.
- Undefined: fft_din_re = {4'd0, adc_data}.
- FLUSH zero-fill is 0 in both cases.

Decomposition:
- Package fft_seq_pkg holds:
  - state enum: IDLE, PRIME, STREAM, FLUSH;
  - ADC_W=12, FFT_W=16;
  - DC_OFFSET=2048.
- One sub-module, fft_seq_decimator, holds dcnt and the accept strobe. The FSM and counters stay in the top.

Test Plan (N_POINTS=8 in sim):
- Single shot, decim=0, buf_ready=1, adc_valid every cycle:
  - 8 enables with ADC data, then 8 consecutive zero enables;
  - capture_en on exactly the 8 FLUSH pushes, with sof on the 1st and eof on the 8th;
  - frame_cnt=1, then IDLE.
- run=1 for 3 frames, then run=0:
  - PRIME, then 2 STREAM frames with capture, then FLUSH;
  - frame_cnt=3, overrun=0.
- decim=2, adc_valid every cycle: fft_enable every 3rd cycle; change decim to 0 mid-frame → spacing unchanged until the next frame.
- buf_ready=0 at the idx==0 of STREAM frame 2: no capture_en for that frame, overrun=1 sticky, frame_cnt skips it; the next frame captures normally.
- rst asserted in STREAM at idx=5: next cycle all outputs 0, state IDLE, frame_cnt=0, no FLUSH.
- adc_data=12'h000 and 12'hFFF: with FFT_SEQ_DC_REMOVE_EN, fft_din_re=16'hF800 and 16'h07FF; without the macro, 16'h0000 and 16'h0FFF.
